// File: rtl/mii_tx_framer_if.sv
`default_nettype none
// ============================================================================
// mii_tx_framer_if : byte-stream handshake between the MAC TX FIFO and framer
// Revision 1.0
// ============================================================================
interface mii_tx_framer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/mii_tx_framer.sv
`default_nettype none
// ============================================================================
// mii_tx_framer : MII nibble framer - preamble, SFD, data, [pad], FCS, IFG.
// Optional zero padding of short frames: define MII_TX_PAD_EN.
// Revision 1.0
// ============================================================================
module mii_tx_framer #(
    parameter int PREAMBLE_NIBBLES = 15,
    parameter int MIN_FRAME_BYTES  = 60,
    parameter int IFG_NIBBLES      = 24
) (
    input  wire            clk,
    input  wire            reset_n,
    mii_tx_framer_if.slave tx,
    output logic [3:0]     mii_txd,
    output logic           mii_txen,
    output logic           busy,
    output logic           frame_done,
    output logic           underrun
);

    localparam int CNT_MAX = (PREAMBLE_NIBBLES > IFG_NIBBLES)
                           ? ((PREAMBLE_NIBBLES > 8) ? PREAMBLE_NIBBLES : 8)
                           : ((IFG_NIBBLES > 8) ? IFG_NIBBLES : 8);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [10:0] MIN_BYTES = 11'(MIN_FRAME_BYTES);
`ifdef MII_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA_LO  = 3'd3,
        ST_DATA_HI  = 3'd4,
`ifdef MII_TX_PAD_EN
        ST_PAD      = 3'd5,
`endif
        ST_FCS      = 3'd6,
        ST_IFG      = 3'd7
    } state_t;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [31:0]      crc_q,      crc_d;
    logic [7:0]       byte_q,     byte_d;
    logic             last_q,     last_d;
    logic [10:0]      bytes_q,    bytes_d;
    logic [3:0]       mii_txd_q,  mii_txd_d;
    logic             mii_txen_q, mii_txen_d;
    logic             tx_ready_q, tx_ready_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             under_q,    under_d;
`ifdef MII_TX_PAD_EN
    logic             pad_hi_q,   pad_hi_d;
`endif

    logic [10:0] bytes_inc;
    logic [3:0]  fcs_nibble;
    logic        pad_needed;

    // Non-reflected CRC-32; nibble bits enter in wire order (bit 0 first).
    function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++) begin
            if (r[31] ^ d[i]) r = (r << 1) ^ 32'h04C1_1DB7;
            else              r = r << 1;
        end
        return r;
    endfunction

    assign bytes_inc  = (bytes_q == 11'h7FF) ? bytes_q : bytes_q + 11'd1;
    assign fcs_nibble = ~{crc_q[28], crc_q[29], crc_q[30], crc_q[31]};
    assign pad_needed = PAD_EN && (bytes_q < MIN_BYTES);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        byte_d     = byte_q;
        last_d     = last_q;
        bytes_d    = bytes_q;
        mii_txd_d  = mii_txd_q;
        mii_txen_d = mii_txen_q;
        tx_ready_d = 1'b0;
        done_d     = 1'b0;
        under_d    = 1'b0;
`ifdef MII_TX_PAD_EN
        pad_hi_d   = pad_hi_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                mii_txen_d = 1'b0;
                mii_txd_d  = 4'h0;
                if (tx.tx_valid) begin
                    state_d    = ST_PREAMBLE;
                    mii_txen_d = 1'b1;
                    mii_txd_d  = 4'h5;
                    cnt_d      = '0;
                    bytes_d    = '0;
                end
            end
            ST_PREAMBLE: begin
                if (cnt_q == CNT_W'(PREAMBLE_NIBBLES - 1)) begin
                    state_d    = ST_SFD;
                    mii_txd_d  = 4'hD;
                    crc_d      = 32'hFFFF_FFFF;
                    tx_ready_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    mii_txd_d = 4'h5;
                end
            end
            ST_SFD, ST_DATA_HI: begin
                if (tx_ready_q) begin
                    if (tx.tx_valid) begin
                        state_d   = ST_DATA_LO;
                        byte_d    = tx.tx_data;
                        last_d    = tx.tx_last;
                        bytes_d   = bytes_inc;
                        mii_txd_d = tx.tx_data[3:0];
                        crc_d     = crc_nibble(crc_q, tx.tx_data[3:0]);
                    end else begin
                        // Starved mid-frame: drop txen, skip the FCS so the PHY sends a runt.
                        state_d    = ST_IFG;
                        mii_txen_d = 1'b0;
                        mii_txd_d  = 4'h0;
                        under_d    = 1'b1;
                        cnt_d      = '0;
                    end
                end else begin
                    if (pad_needed) begin
`ifdef MII_TX_PAD_EN
                        state_d   = ST_PAD;
                        pad_hi_d  = 1'b0;
                        mii_txd_d = 4'h0;
                        crc_d     = crc_nibble(crc_q, 4'h0);
`endif
                    end else begin
                        state_d   = ST_FCS;
                        mii_txd_d = fcs_nibble;
                        crc_d     = crc_q << 4;
                        cnt_d     = '0;
                    end
                end
            end
            ST_DATA_LO: begin
                state_d    = ST_DATA_HI;
                mii_txd_d  = byte_q[7:4];
                crc_d      = crc_nibble(crc_q, byte_q[7:4]);
                tx_ready_d = ~last_q;
            end
`ifdef MII_TX_PAD_EN
            ST_PAD: begin
                if (!pad_hi_q) begin
                    pad_hi_d  = 1'b1;
                    mii_txd_d = 4'h0;
                    crc_d     = crc_nibble(crc_q, 4'h0);
                end else begin
                    bytes_d = bytes_inc;
                    if (bytes_inc >= MIN_BYTES) begin
                        state_d   = ST_FCS;
                        mii_txd_d = fcs_nibble;
                        crc_d     = crc_q << 4;
                        cnt_d     = '0;
                    end else begin
                        pad_hi_d  = 1'b0;
                        mii_txd_d = 4'h0;
                        crc_d     = crc_nibble(crc_q, 4'h0);
                    end
                end
            end
`endif
            ST_FCS: begin
                if (cnt_q == CNT_W'(7)) begin
                    state_d    = ST_IFG;
                    mii_txen_d = 1'b0;
                    mii_txd_d  = 4'h0;
                    done_d     = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    mii_txd_d = fcs_nibble;
                    crc_d     = crc_q << 4;
                end
            end
            ST_IFG: begin
                mii_txen_d = 1'b0;
                mii_txd_d  = 4'h0;
                if (cnt_q == CNT_W'(IFG_NIBBLES - 1)) begin
                    // A queued frame starts right away so the gap is exactly IFG_NIBBLES.
                    if (tx.tx_valid) begin
                        state_d    = ST_PREAMBLE;
                        mii_txen_d = 1'b1;
                        mii_txd_d  = 4'h5;
                        cnt_d      = '0;
                        bytes_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                mii_txen_d = 1'b0;
                mii_txd_d  = 4'h0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            crc_q      <= 32'hFFFF_FFFF;
            byte_q     <= 8'h00;
            last_q     <= 1'b0;
            bytes_q    <= '0;
            mii_txd_q  <= 4'h0;
            mii_txen_q <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            under_q    <= 1'b0;
`ifdef MII_TX_PAD_EN
            pad_hi_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            byte_q     <= byte_d;
            last_q     <= last_d;
            bytes_q    <= bytes_d;
            mii_txd_q  <= mii_txd_d;
            mii_txen_q <= mii_txen_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            under_q    <= under_d;
`ifdef MII_TX_PAD_EN
            pad_hi_q   <= pad_hi_d;
`endif
        end
    end

    assign mii_txd     = mii_txd_q;
    assign mii_txen    = mii_txen_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign underrun    = under_q;
    assign tx.tx_ready = tx_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_mii_tx_framer.sv
`default_nettype none
// ============================================================================
// tb_mii_tx_framer : directed self-checking bench for mii_tx_framer
// Revision 1.0
// ============================================================================
module tb_mii_tx_framer;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    mii_tx_framer_if tif();
    logic [3:0] mii_txd;
    logic       mii_txen, busy, frame_done, underrun;

    mii_tx_framer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx         (tif),
        .mii_txd    (mii_txd),
        .mii_txen   (mii_txen),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [3:0] rx_q[$];
    logic [7:0] exp_q[$];
    int  cyc = 0, rise_cyc = 0, start_cyc = 0;
    int  last_gap = -1, low_run = 0, pos = 0;
    int  hs_cnt = 0, hs_bad = 0, fd_cnt = 0, fd_aligned = 0, ur_cnt = 0, ur_aligned = 0;
    bit  had_high = 1'b0, prev_txen = 1'b0;
    int  fd0, ur0, hs0, hb0, fa0, ua0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            if (mii_txen) begin
                if (!prev_txen) begin
                    if (had_high) last_gap = low_run;
                    rise_cyc = cyc;
                    pos      = 0;
                end else begin
                    pos++;
                end
                had_high = 1'b1;
                low_run  = 0;
                rx_q.push_back(mii_txd);
            end else begin
                low_run++;
            end
            if (tif.tx_valid && tif.tx_ready) begin
                hs_cnt++;
                if (!mii_txen || pos < 15) hs_bad++;
            end
            if (frame_done) begin
                fd_cnt++;
                if (prev_txen && !mii_txen) fd_aligned++;
            end
            if (underrun) begin
                ur_cnt++;
                if (prev_txen && !mii_txen) ur_aligned++;
            end
            prev_txen = mii_txen;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] nib(input int i);
        if (i >= 0 && i < rx_q.size()) return rx_q[i];
        return 4'hx;
    endfunction

    // Reflected byte-wise reference CRC; FCS goes on the wire LSB first.
    function automatic logic [31:0] fcs_model();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (exp_q[i]) begin
            c = c ^ {24'd0, exp_q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [31:0] rx_residue(input int from);
        logic [31:0] c;
        logic [3:0]  d;
        c = 32'hFFFF_FFFF;
        for (int i = from; i < rx_q.size(); i++) begin
            d = rx_q[i];
            for (int b = 0; b < 4; b++) c = (c[31] ^ d[b]) ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
        end
        return c;
    endfunction

    task automatic snapshot();
        rx_q.delete();
        exp_q.delete();
        fd0 = fd_cnt; ur0 = ur_cnt; hs0 = hs_cnt; hb0 = hs_bad; fa0 = fd_aligned; ua0 = ur_aligned;
    endtask

    task automatic send_frame(input string tag, input int len, input logic [7:0] base, input int drop_at);
        int  idx   = 0;
        int  guard = 0;
        bit  hs;
        int  target;
        target       = (drop_at >= 0) ? drop_at : len;
        tif.tx_data  = base;
        tif.tx_last  = (len == 1);
        tif.tx_valid = 1'b1;
        while (idx < target && guard < 4 * len + 200) begin
            @(negedge clk);
            hs = tif.tx_valid && tif.tx_ready;
            @(posedge clk);
            #1;
            guard++;
            if (hs) begin
                idx++;
                tif.tx_data = 8'(base + 8'(idx));
                tif.tx_last = (idx == len - 1);
            end
            if (idx >= target) tif.tx_valid = 1'b0;
        end
        tif.tx_valid = 1'b0;
        check({tag, "_sent"}, idx, target);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < bound);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag);
        int n_data, mism;
        logic [31:0] fcs_obs;
        n_data = exp_q.size();
        check({tag, "_nibbles"}, rx_q.size(), 16 + 2 * n_data + 8);
        mism = 0;
        for (int i = 0; i < 15; i++) if (nib(i) !== 4'h5) mism++;
        check({tag, "_preamble"}, mism, 0);
        check({tag, "_sfd"}, {28'd0, nib(15)}, 32'hD);
        mism = 0;
        foreach (exp_q[i]) begin
            if (nib(16 + 2 * i) !== exp_q[i][3:0]) mism++;
            if (nib(17 + 2 * i) !== exp_q[i][7:4]) mism++;
        end
        check({tag, "_data"}, mism, 0);
        for (int k = 0; k < 8; k++) fcs_obs[4*k +: 4] = nib(16 + 2 * n_data + k);
        check({tag, "_fcs"}, fcs_obs, fcs_model());
        check({tag, "_residue"}, rx_residue(16), 32'hC704_DD7B);
    endtask

    initial begin
        int k;
        tif.tx_valid = 1'b0;
        tif.tx_data  = 8'h00;
        tif.tx_last  = 1'b0;

        // Reset state
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txen",  {31'd0, mii_txen},     32'd0);
        check("rst_txd",   {28'd0, mii_txd},      32'd0);
        check("rst_busy",  {31'd0, busy},         32'd0);
        check("rst_ready", {31'd0, tif.tx_ready}, 32'd0);
        check("rst_done",  {31'd0, frame_done},   32'd0);
        check("rst_ur",    {31'd0, underrun},     32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 60-byte frame 0x00..0x3B
        snapshot();
        for (int i = 0; i < 60; i++) exp_q.push_back(8'(i));
        start_cyc = cyc;
        send_frame("t1", 60, 8'h00, -1);
        wait_idle("t1", 400);
        check("t1_latency", rise_cyc - start_cyc, 1);
        check("t1_txd16", {28'd0, nib(16)}, 32'h0);
        check("t1_txd18", {28'd0, nib(18)}, 32'h1);
        check_frame("t1");
        check("t1_done", fd_cnt - fd0, 1);
        check("t1_done_align", fd_aligned - fa0, 1);
        check("t1_ur", ur_cnt - ur0, 0);
        check("t1_hs", hs_cnt - hs0, 60);

        // 1-byte frame 0xAB
        snapshot();
        exp_q.push_back(8'hAB);
`ifdef MII_TX_PAD_EN
        for (int i = 0; i < 59; i++) exp_q.push_back(8'h00);
`endif
        send_frame("t2", 1, 8'hAB, -1);
        wait_idle("t2", 400);
        check("t2_lo", {28'd0, nib(16)}, 32'hB);
        check("t2_hi", {28'd0, nib(17)}, 32'hA);
`ifdef MII_TX_PAD_EN
        check("t2_txen_cycles", rx_q.size(), 144);
`else
        check("t2_txen_cycles", rx_q.size(), 26);
`endif
        check_frame("t2");
        check("t2_done", fd_cnt - fd0, 1);

        // Underrun at the 5th byte request
        snapshot();
        send_frame("t3", 10, 8'h40, 4);
        k = 0;
        while (!underrun && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t3_ur_seen", {31'd0, underrun}, 32'd1);
        check("t3_txen_low", {31'd0, mii_txen}, 32'd0);
        check("t3_ur_align", ur_aligned - ua0, 1);
        @(negedge clk);
        check("t3_ur_pulse", {31'd0, underrun}, 32'd0);
        repeat (22) @(negedge clk);
        check("t3_busy_ifg", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t3_busy_end", {31'd0, busy}, 32'd0);
        check("t3_txen_cycles", rx_q.size(), 24);
        check("t3_no_done", fd_cnt - fd0, 0);
        check("t3_ur_count", ur_cnt - ur0, 1);
        @(posedge clk);
        #1;

        // Back-to-back frames
        snapshot();
        send_frame("t4a", 8, 8'h20, -1);
        send_frame("t4b", 8, 8'h80, -1);
        wait_idle("t4", 400);
        check("t4_gap", last_gap, 24);
        check("t4_nibbles", rx_q.size(), 2 * (16 + 16 + 8));
        check("t4_done", fd_cnt - fd0, 2);

        // Asynchronous reset mid-data, then a clean frame
        snapshot();
        tif.tx_data  = 8'h5A;
        tif.tx_last  = 1'b0;
        tif.tx_valid = 1'b1;
        repeat (30) @(posedge clk);
        #3;
        check("t5_pre_txen", {31'd0, mii_txen}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_txen",  {31'd0, mii_txen},     32'd0);
        check("t5_rst_busy",  {31'd0, busy},         32'd0);
        check("t5_rst_ready", {31'd0, tif.tx_ready}, 32'd0);
        tif.tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        snapshot();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'hC3 + 8'(i)));
        send_frame("t5", 8, 8'hC3, -1);
        wait_idle("t5", 400);
        check_frame("t5");
        check("t5_done", fd_cnt - fd0, 1);

        // 1500-byte frame handshake count
        snapshot();
        for (int i = 0; i < 1500; i++) exp_q.push_back(8'(i));
        send_frame("t6", 1500, 8'h00, -1);
        wait_idle("t6", 400);
        check("t6_hs", hs_cnt - hs0, 1500);
        check("t6_hs_outside", hs_bad - hb0, 0);
        check_frame("t6");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
